// File: rtl/param_wb_cache_if.sv
// Core-side (UFP) and memory-side (DFP) bus bundle for param_wb_cache.
// The cache uses the slave modport; the core/memory environment uses master.
interface param_wb_cache_if;
   logic [31:0]  ufp_addr;
   logic [3:0]   ufp_rmask;
   logic [3:0]   ufp_wmask;
   logic [31:0]  ufp_wdata;
   logic [31:0]  ufp_rdata;
   logic         ufp_resp;
   logic [31:0]  dfp_addr;
   logic         dfp_read;
   logic         dfp_write;
   logic [255:0] dfp_wdata;
   logic [255:0] dfp_rdata;
   logic         dfp_resp;

   modport slave (
      input  ufp_addr, ufp_rmask, ufp_wmask, ufp_wdata, dfp_rdata, dfp_resp,
      output ufp_rdata, ufp_resp, dfp_addr, dfp_read, dfp_write, dfp_wdata
   );

   modport master (
      output ufp_addr, ufp_rmask, ufp_wmask, ufp_wdata, dfp_rdata, dfp_resp,
      input  ufp_rdata, ufp_resp, dfp_addr, dfp_read, dfp_write, dfp_wdata
   );
endinterface

// File: rtl/param_wb_cache.sv
// Write-back, write-allocate, N-way set-associative data cache with tree-PLRU
// replacement (invalid ways preferred), flush/invalidate walk and hit/miss
// counters. Storage is flip-flops with combinational read.
module param_wb_cache #(
   parameter int NUM_WAYS = 4,
   parameter int NUM_SETS = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   param_wb_cache_if.slave      bus,
   input  logic                 flush_req,
   input  logic                 flush_inv,
   output logic                 flush_done,
   output logic                 busy,
   output logic [31:0]          hit_count,
   output logic [31:0]          miss_count
);
   localparam int IDX_W  = $clog2(NUM_SETS);
   localparam int TAG_W  = 27 - IDX_W;
   localparam int WAY_W  = $clog2(NUM_WAYS);
   localparam int PLRU_W = NUM_WAYS - 1;
   localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(NUM_WAYS - 1);
   localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(NUM_SETS - 1);

   typedef enum logic [2:0] {
      IDLE, COMPARE, WRITE_BACK, ALLOCATE, STALL, FLUSH_SCAN, FLUSH_WB
   } state_t;

   state_t state_q;

   // Per-set/per-way state; flags are reset, tags and lines are not.
   logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_q, dirty_q;
   logic [NUM_SETS-1:0][PLRU_W-1:0]   plru_q;
   logic [TAG_W-1:0]                  tag_q  [NUM_SETS][NUM_WAYS];
   logic [255:0]                      line_q [NUM_SETS][NUM_WAYS];

   logic [WAY_W-1:0] vic_q;
   logic [IDX_W-1:0] fl_set;
   logic [WAY_W-1:0] fl_way;
   logic             fl_inv;

   logic [31:0]  ufp_rdata_q;
   logic         ufp_resp_q;
   logic [31:0]  dfp_addr_q;
   logic         dfp_read_q, dfp_write_q;
   logic [255:0] dfp_wdata_q;

   assign bus.ufp_rdata = ufp_rdata_q;
   assign bus.ufp_resp  = ufp_resp_q;
   assign bus.dfp_addr  = dfp_addr_q;
   assign bus.dfp_read  = dfp_read_q;
   assign bus.dfp_write = dfp_write_q;
   assign bus.dfp_wdata = dfp_wdata_q;

   // Walk the tree from the root; a 0 bit sends the victim to the lower half.
   function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] t);
      int node;
      logic [PLRU_W-1:0] sh;
      node = 0;
      for (int l = 0; l < WAY_W; l++) begin
         sh   = t >> node;
         node = 2 * node + 1 + int'(sh[0]);
      end
      return WAY_W'(node - PLRU_W);
   endfunction

   // Point every bit on the accessed way's path away from it.
   function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] t,
                                                    input logic [WAY_W-1:0]  w);
      logic [PLRU_W-1:0] r;
      logic d;
      int node;
      r    = t;
      node = 0;
      for (int l = 0; l < WAY_W; l++) begin
         d    = w[WAY_W-1-l];
         r    = (r & ~(PLRU_W'(1) << node)) | (PLRU_W'(!d) << node);
         node = 2 * node + 1 + int'(d);
      end
      return r;
   endfunction

   logic [TAG_W-1:0] tag_in;
   logic [IDX_W-1:0] idx;
   logic [2:0]       word;
   logic             unused_ok;

   assign tag_in    = bus.ufp_addr[31:5+IDX_W];
   assign idx       = bus.ufp_addr[4+IDX_W:5];
   assign word      = bus.ufp_addr[4:2];
   assign unused_ok = ^bus.ufp_addr[1:0];

   logic             hit, inv_found, req, lookup_now, do_hit, wr_hit, fill, fl_adv, fl_last;
   logic [WAY_W-1:0] hit_way, inv_way, victim;
   logic [31:0]      hit_word, rdata_m;
   logic [31:0]      alloc_addr;

   // Tag lookup, victim choice and masked read data for the current request.
   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (valid_q[idx][w] && tag_q[idx][w] == tag_in) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (!valid_q[idx][w]) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
      end
      victim   = inv_found ? inv_way : plru_victim(plru_q[idx]);
      hit_word = line_q[idx][hit_way][{word, 5'b0} +: 32];
      for (int b = 0; b < 4; b++)
         rdata_m[8*b +: 8] = bus.ufp_rmask[b] ? hit_word[8*b +: 8] : 8'h00;
   end

   // Hits are resolved on the edge leaving IDLE/STALL so the response is
   // registered and lands in the COMPARE cycle.
   assign req        = (|bus.ufp_rmask) || (|bus.ufp_wmask);
   assign lookup_now = req && ((state_q == IDLE && !flush_req) || state_q == STALL);
   assign do_hit     = lookup_now && hit;
   assign wr_hit     = do_hit && (|bus.ufp_wmask);
   assign fill       = (state_q == ALLOCATE) && bus.dfp_resp;
   assign alloc_addr = {bus.ufp_addr[31:5], 5'b0};
   assign fl_last    = (fl_set == LAST_SET) && (fl_way == LAST_WAY);
   assign fl_adv     = (state_q == FLUSH_SCAN && !(valid_q[fl_set][fl_way] && dirty_q[fl_set][fl_way]))
                    || (state_q == FLUSH_WB && bus.dfp_resp);

   // Line and tag storage: fills from memory and byte-merged write hits.
   always_ff @(posedge clk) begin
      if (fill) begin
         line_q[idx][vic_q] <= bus.dfp_rdata;
         tag_q[idx][vic_q]  <= tag_in;
      end else if (wr_hit) begin
         for (int b = 0; b < 4; b++)
            if (bus.ufp_wmask[b])
               line_q[idx][hit_way][{word, 2'(b), 3'b0} +: 8] <= bus.ufp_wdata[8*b +: 8];
      end
   end

   // Control FSM, metadata flags, counters and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         valid_q     <= '0;
         dirty_q     <= '0;
         plru_q      <= '0;
         hit_count   <= '0;
         miss_count  <= '0;
         ufp_resp_q  <= 1'b0;
         ufp_rdata_q <= '0;
         dfp_read_q  <= 1'b0;
         dfp_write_q <= 1'b0;
         dfp_addr_q  <= '0;
         dfp_wdata_q <= '0;
         flush_done  <= 1'b0;
         busy        <= 1'b0;
         vic_q       <= '0;
         fl_set      <= '0;
         fl_way      <= '0;
         fl_inv      <= 1'b0;
      end else begin
         ufp_resp_q <= 1'b0;
         flush_done <= 1'b0;
         if (do_hit) begin
            ufp_resp_q  <= 1'b1;
            ufp_rdata_q <= rdata_m;
            plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
            hit_count   <= hit_count + 32'd1;
            if (|bus.ufp_wmask) dirty_q[idx][hit_way] <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (flush_req) begin
                  state_q <= FLUSH_SCAN;
                  busy    <= 1'b1;
                  fl_set  <= '0;
                  fl_way  <= '0;
                  fl_inv  <= flush_inv;
                  if (flush_inv) plru_q <= '0;
               end else if (req) begin
                  state_q <= COMPARE;
                  busy    <= 1'b1;
               end
            end
            COMPARE: begin
               if (hit) begin
                  state_q <= IDLE;
                  busy    <= 1'b0;
               end else begin
                  miss_count <= miss_count + 32'd1;
                  vic_q      <= victim;
                  if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
                     dfp_write_q <= 1'b1;
                     dfp_addr_q  <= {tag_q[idx][victim], idx, 5'b0};
                     dfp_wdata_q <= line_q[idx][victim];
                     state_q     <= WRITE_BACK;
                  end else begin
                     dfp_read_q <= 1'b1;
                     dfp_addr_q <= alloc_addr;
                     state_q    <= ALLOCATE;
                  end
               end
            end
            WRITE_BACK: begin
               if (bus.dfp_resp) begin
                  dirty_q[idx][vic_q] <= 1'b0;
                  dfp_write_q         <= 1'b0;
                  dfp_read_q          <= 1'b1;
                  dfp_addr_q          <= alloc_addr;
                  state_q             <= ALLOCATE;
               end
            end
            ALLOCATE: begin
               if (bus.dfp_resp) begin
                  dfp_read_q          <= 1'b0;
                  valid_q[idx][vic_q] <= 1'b1;
                  dirty_q[idx][vic_q] <= 1'b0;
                  state_q             <= STALL;
               end
            end
            STALL: state_q <= COMPARE;
            FLUSH_SCAN: begin
               if (valid_q[fl_set][fl_way] && dirty_q[fl_set][fl_way]) begin
                  dfp_write_q <= 1'b1;
                  dfp_addr_q  <= {tag_q[fl_set][fl_way], fl_set, 5'b0};
                  dfp_wdata_q <= line_q[fl_set][fl_way];
                  state_q     <= FLUSH_WB;
               end else if (fl_inv) begin
                  valid_q[fl_set][fl_way] <= 1'b0;
               end
            end
            FLUSH_WB: begin
               if (bus.dfp_resp) begin
                  dfp_write_q             <= 1'b0;
                  dirty_q[fl_set][fl_way] <= 1'b0;
                  if (fl_inv) valid_q[fl_set][fl_way] <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
         // Shared pointer step for both flush states.
         if (fl_adv) begin
            if (fl_last) begin
               flush_done <= 1'b1;
               busy       <= 1'b0;
               state_q    <= IDLE;
            end else begin
               state_q <= FLUSH_SCAN;
               if (fl_way == LAST_WAY) begin
                  fl_way <= '0;
                  fl_set <= fl_set + IDX_W'(1);
               end else begin
                  fl_way <= fl_way + WAY_W'(1);
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_param_wb_cache.sv
// Directed self-checking bench for param_wb_cache (4 ways, 16 sets) with a
// fixed-latency line memory model.
module tb_param_wb_cache;
   localparam int LAT      = 3;
   localparam int MISS_CYC = LAT + 3;      // clean miss: request to ufp_resp
   localparam int DIRTY_CYC = 2 * LAT + 3; // dirty miss
   localparam int SCAN_CYC = 64;           // 4 ways x 16 sets

   logic clk, rst_n, flush_req, flush_inv, flush_done, busy;
   logic [31:0] hit_count, miss_count;
   int errors, checks;

   param_wb_cache_if bus();

   param_wb_cache #(.NUM_WAYS(4), .NUM_SETS(16)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .flush_req(flush_req), .flush_inv(flush_inv), .flush_done(flush_done),
      .busy(busy), .hit_count(hit_count), .miss_count(miss_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [255:0] mem [logic [31:0]];
   logic [31:0]  tx_addr [$];
   bit           tx_wr [$];

   // Untouched memory lines hold each word's own byte address.
   function automatic logic [255:0] line_of(input logic [31:0] a);
      logic [255:0] l;
      if (mem.exists(a)) return mem[a];
      for (int i = 0; i < 8; i++) l[32*i +: 32] = a + 32'(4 * i);
      return l;
   endfunction

   // Memory responder: dfp_resp after LAT cycles of a held request.
   initial begin
      int lat;
      lat = 0;
      bus.dfp_resp  = 1'b0;
      bus.dfp_rdata = '0;
      forever begin
         @(negedge clk);
         bus.dfp_resp = 1'b0;
         if (!rst_n || !(bus.dfp_read || bus.dfp_write)) lat = 0;
         else begin
            lat++;
            if (lat == LAT) begin
               lat = 0;
               tx_addr.push_back(bus.dfp_addr);
               tx_wr.push_back(bus.dfp_write);
               if (bus.dfp_write) mem[bus.dfp_addr] = bus.dfp_wdata;
               else bus.dfp_rdata = line_of(bus.dfp_addr);
               bus.dfp_resp = 1'b1;
            end
         end
      end
   end

   task automatic access(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                         input logic [31:0] wd, output logic [31:0] rd, output int cyc);
      @(negedge clk);
      bus.ufp_addr = a; bus.ufp_rmask = rm; bus.ufp_wmask = wm; bus.ufp_wdata = wd;
      cyc = 0;
      while (cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (bus.ufp_resp) break;
      end
      rd = bus.ufp_rdata;
      bus.ufp_rmask = 4'h0; bus.ufp_wmask = 4'h0;
   endtask

   task automatic apply_reset();
      bus.ufp_rmask = 4'h0; bus.ufp_wmask = 4'h0;
      flush_req = 1'b0; flush_inv = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (hit_count !== 32'd0) begin errors++; $display("FAIL reset_hits got=%0d exp=0", hit_count); end
      checks++; if (miss_count !== 32'd0) begin errors++; $display("FAIL reset_misses got=%0d exp=0", miss_count); end
      checks++; if ({bus.ufp_resp, bus.dfp_read, bus.dfp_write, flush_done} !== 4'b0)
         begin errors++; $display("FAIL reset_strobes got=%b exp=0000", {bus.ufp_resp, bus.dfp_read, bus.dfp_write, flush_done}); end
   endtask

   task automatic test_read_miss();
      logic [31:0] rd; int cyc;
      tx_addr.delete(); tx_wr.delete();
      access(32'h0000_1004, 4'hF, 4'h0, 32'h0, rd, cyc);
      checks++; if (cyc !== MISS_CYC) begin errors++; $display("FAIL miss_latency got=%0d exp=%0d", cyc, MISS_CYC); end
      checks++; if (rd !== 32'hAABB_CCDD) begin errors++; $display("FAIL miss_rdata got=%h exp=aabbccdd", rd); end
      checks++; if (tx_addr.size() !== 1 || tx_addr[0] !== 32'h0000_1000 || tx_wr[0] !== 1'b0)
         begin errors++; $display("FAIL miss_dfp count=%0d exp one read at 00001000", tx_addr.size()); end
      checks++; if (miss_count !== 32'd1 || hit_count !== 32'd1)
         begin errors++; $display("FAIL miss_counters got hit=%0d miss=%0d exp hit=1 miss=1", hit_count, miss_count); end
   endtask

   task automatic test_write_hit();
      logic [31:0] rd; int cyc;
      tx_addr.delete(); tx_wr.delete();
      access(32'h0000_1004, 4'h0, 4'b0011, 32'h1234_5678, rd, cyc);
      checks++; if (cyc !== 1) begin errors++; $display("FAIL wr_hit_latency got=%0d exp=1", cyc); end
      access(32'h0000_1004, 4'hF, 4'h0, 32'h0, rd, cyc);
      checks++; if (cyc !== 1) begin errors++; $display("FAIL rd_hit_latency got=%0d exp=1", cyc); end
      checks++; if (rd !== 32'hAABB_5678) begin errors++; $display("FAIL wr_merge got=%h exp=aabb5678", rd); end
      access(32'h0000_1004, 4'b1100, 4'h0, 32'h0, rd, cyc);
      checks++; if (rd !== 32'hAABB_0000) begin errors++; $display("FAIL rmask_zero got=%h exp=aabb0000", rd); end
      checks++; if (tx_addr.size() !== 0) begin errors++; $display("FAIL hit_no_dfp got=%0d exp=0", tx_addr.size()); end
      checks++; if (hit_count !== 32'd4 || miss_count !== 32'd1)
         begin errors++; $display("FAIL hit_counters got hit=%0d miss=%0d exp hit=4 miss=1", hit_count, miss_count); end
   endtask

   // Set 3, tags 0x10..0x15: A=2060 B=2260 C=2460 D=2660 E=2860 F=2A60.
   task automatic test_plru_evict();
      logic [31:0] rd; int cyc;
      access(32'h2060, 4'hF, 4'h0, 32'h0, rd, cyc);
      access(32'h2260, 4'hF, 4'h0, 32'h0, rd, cyc);
      access(32'h2460, 4'hF, 4'h0, 32'h0, rd, cyc);
      access(32'h2660, 4'h0, 4'hF, 32'h0D0D_0D0D, rd, cyc);
      checks++; if (cyc !== MISS_CYC) begin errors++; $display("FAIL fill4_latency got=%0d exp=%0d", cyc, MISS_CYC); end
      tx_addr.delete(); tx_wr.delete();
      access(32'h2860, 4'hF, 4'h0, 32'h0, rd, cyc);
      checks++; if (tx_addr.size() !== 1 || tx_addr[0] !== 32'h2860 || tx_wr[0] !== 1'b0)
         begin errors++; $display("FAIL evict_clean count=%0d exp one read at 00002860", tx_addr.size()); end
      // A was the victim: it misses again, landing in C's way.
      access(32'h2060, 4'h0, 4'hF, 32'hDEAD_BEEF, rd, cyc);
      checks++; if (cyc !== MISS_CYC) begin errors++; $display("FAIL a_refill_latency got=%0d exp=%0d", cyc, MISS_CYC); end
      access(32'h2260, 4'hF, 4'h0, 32'h0, rd, cyc);
      checks++; if (cyc !== 1) begin errors++; $display("FAIL b_hit got=%0d exp=1", cyc); end
      access(32'h2660, 4'hF, 4'h0, 32'h0, rd, cyc);
      checks++; if (rd !== 32'h0D0D_0D0D) begin errors++; $display("FAIL d_hit_data got=%h exp=0d0d0d0d", rd); end
      access(32'h2860, 4'hF, 4'h0, 32'h0, rd, cyc);
      checks++; if (cyc !== 1) begin errors++; $display("FAIL e_hit got=%0d exp=1", cyc); end
      tx_addr.delete(); tx_wr.delete();
      access(32'h2A60, 4'hF, 4'h0, 32'h0, rd, cyc);
      checks++; if (cyc !== DIRTY_CYC) begin errors++; $display("FAIL dirty_latency got=%0d exp=%0d", cyc, DIRTY_CYC); end
      checks++; if (tx_addr.size() !== 2 || tx_addr[0] !== 32'h2060 || tx_wr[0] !== 1'b1 ||
                    tx_addr[1] !== 32'h2A60 || tx_wr[1] !== 1'b0)
         begin errors++; $display("FAIL dirty_order count=%0d exp write 2060 then read 2a60", tx_addr.size()); end
      checks++; if (!mem.exists(32'h2060) || mem[32'h2060][31:0] !== 32'hDEAD_BEEF)
         begin errors++; $display("FAIL wb_data got=%h exp=deadbeef", line_of(32'h2060)); end
      checks++; if (rd !== 32'h2A60) begin errors++; $display("FAIL f_rdata got=%h exp=00002a60", rd); end
      checks++; if (hit_count !== 32'd14 || miss_count !== 32'd8)
         begin errors++; $display("FAIL plru_counters got hit=%0d miss=%0d exp hit=14 miss=8", hit_count, miss_count); end
   endtask

   task automatic test_flush_inv();
      logic [31:0] rd; int cyc; bit busy_seen;
      apply_reset();
      access(32'h4000, 4'h0, 4'hF, 32'h1111_0000, rd, cyc);
      access(32'h40A0, 4'h0, 4'hF, 32'h5555_0000, rd, cyc);
      access(32'h41E0, 4'h0, 4'hF, 32'hFFFF_0000, rd, cyc);
      access(32'h4040, 4'hF, 4'h0, 32'h0, rd, cyc);
      tx_addr.delete(); tx_wr.delete();
      @(negedge clk);
      flush_req = 1'b1; flush_inv = 1'b1;
      cyc = 0; busy_seen = 1'b0;
      while (cyc < 500) begin
         @(negedge clk);
         flush_req = 1'b0; flush_inv = 1'b0;
         cyc++;
         if (cyc == 1) busy_seen = busy;
         if (flush_done) break;
      end
      checks++; if (cyc !== SCAN_CYC + 3 * LAT + 1)
         begin errors++; $display("FAIL flush_done_cycle got=%0d exp=%0d", cyc, SCAN_CYC + 3 * LAT + 1); end
      checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL flush_busy got=%b exp=1", busy_seen); end
      checks++; if (tx_addr.size() !== 3 || tx_addr[0] !== 32'h4000 || tx_addr[1] !== 32'h40A0 ||
                    tx_addr[2] !== 32'h41E0 || !(tx_wr[0] && tx_wr[1] && tx_wr[2]))
         begin errors++; $display("FAIL flush_writes count=%0d exp writes 4000,40a0,41e0", tx_addr.size()); end
      checks++; if (!mem.exists(32'h40A0) || mem[32'h40A0][31:0] !== 32'h5555_0000)
         begin errors++; $display("FAIL flush_data got=%h exp=55550000", line_of(32'h40A0)); end
      access(32'h4000, 4'hF, 4'h0, 32'h0, rd, cyc);
      checks++; if (cyc !== MISS_CYC || rd !== 32'h1111_0000)
         begin errors++; $display("FAIL post_flush_dirty cyc=%0d rd=%h exp cyc=%0d rd=11110000", cyc, rd, MISS_CYC); end
      access(32'h4040, 4'hF, 4'h0, 32'h0, rd, cyc);
      checks++; if (cyc !== MISS_CYC) begin errors++; $display("FAIL post_flush_clean got=%0d exp=%0d", cyc, MISS_CYC); end
      checks++; if (hit_count !== 32'd6 || miss_count !== 32'd6)
         begin errors++; $display("FAIL flush_counters got hit=%0d miss=%0d exp hit=6 miss=6", hit_count, miss_count); end
   endtask

   task automatic test_flush_vs_read();
      int cyc, done_cyc, resp_cyc; logic [31:0] rd;
      tx_addr.delete(); tx_wr.delete();
      @(negedge clk);
      flush_req = 1'b1; flush_inv = 1'b0;
      bus.ufp_addr = 32'h4000; bus.ufp_rmask = 4'hF; bus.ufp_wmask = 4'h0;
      cyc = 0; done_cyc = 0; resp_cyc = 0; rd = '0;
      while (cyc < 500) begin
         @(negedge clk);
         flush_req = 1'b0;
         cyc++;
         if (flush_done) done_cyc = cyc;
         if (bus.ufp_resp) begin resp_cyc = cyc; rd = bus.ufp_rdata; break; end
      end
      bus.ufp_rmask = 4'h0;
      checks++; if (done_cyc !== SCAN_CYC + 1) begin errors++; $display("FAIL flush_first got=%0d exp=%0d", done_cyc, SCAN_CYC + 1); end
      checks++; if (resp_cyc !== SCAN_CYC + 2) begin errors++; $display("FAIL read_after got=%0d exp=%0d", resp_cyc, SCAN_CYC + 2); end
      checks++; if (rd !== 32'h1111_0000) begin errors++; $display("FAIL read_after_data got=%h exp=11110000", rd); end
      checks++; if (tx_addr.size() !== 0) begin errors++; $display("FAIL clean_flush_dfp got=%0d exp=0", tx_addr.size()); end
   endtask

   task automatic test_reset_mid_read();
      logic [31:0] rd; int cyc; bit seen;
      @(negedge clk);
      bus.ufp_addr = 32'h6000; bus.ufp_rmask = 4'hF; bus.ufp_wmask = 4'h0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = bus.dfp_read;
      end
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL mid_read_seen got=%b exp=1", seen); end
      rst_n = 1'b0;
      bus.ufp_rmask = 4'h0;
      #1;
      checks++; if ({bus.dfp_read, bus.dfp_write, bus.ufp_resp, busy, flush_done} !== 5'b0)
         begin errors++; $display("FAIL async_reset got=%b exp=00000", {bus.dfp_read, bus.dfp_write, bus.ufp_resp, busy, flush_done}); end
      checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0)
         begin errors++; $display("FAIL async_reset_counters got hit=%0d miss=%0d exp 0", hit_count, miss_count); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tx_addr.delete(); tx_wr.delete();
      access(32'h6000, 4'hF, 4'h0, 32'h0, rd, cyc);
      checks++; if (cyc !== MISS_CYC || rd !== 32'h6000)
         begin errors++; $display("FAIL reread cyc=%0d rd=%h exp cyc=%0d rd=00006000", cyc, rd, MISS_CYC); end
      checks++; if (miss_count !== 32'd1 || tx_addr.size() !== 1)
         begin errors++; $display("FAIL reread_miss miss=%0d tx=%0d exp 1 and 1", miss_count, tx_addr.size()); end
   endtask

   initial begin
      logic [255:0] l;
      errors = 0; checks = 0;
      rst_n = 1'b0; flush_req = 1'b0; flush_inv = 1'b0;
      bus.ufp_addr = '0; bus.ufp_rmask = '0; bus.ufp_wmask = '0; bus.ufp_wdata = '0;
      l = line_of(32'h1000);
      l[63:32] = 32'hAABB_CCDD;
      mem[32'h1000] = l;
      test_reset();
      test_read_miss();
      test_write_hit();
      test_plru_evict();
      test_flush_inv();
      test_flush_vs_read();
      test_reset_mid_read();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/param_wb_cache.md
# param_wb_cache

Parametrised, write-back, write-allocate, N-way set-associative data cache. It sits between the pipelined core's memory stage (UFP, 32-bit word accesses) and the 256-bit line memory port (DFP). It generalises the current fixed 4-way/16-set data cache in four ways: configurable way and set counts, a tree-PLRU that prefers invalid ways, a whole-cache flush/invalidate walk, and hit/miss counters. Storage is flip-flop arrays with combinational read, so no SRAM macros are needed.

## Interface

- NUM_WAYS, 4, associativity; power of two, 2..8
- NUM_SETS, 16, set count; power of two, 2..64
- Derived values: IDX_W = log2(NUM_SETS); TAG_W = 27 - IDX_W; line size is fixed at 32 bytes (offset = addr[4:0])
- Reset: asynchronous and active-low (rst_n)

- clk  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- ufp_addr  in  32  word address; [1:0] is always 0
- ufp_rmask  in  4  byte read mask; nonzero means read request
- ufp_wmask  in  4  byte write mask; nonzero means write request (never both nonzero)
- ufp_wdata  in  32  write data
- ufp_rdata  out  32  read data, valid while ufp_resp=1
- ufp_resp  out  1  one-cycle completion pulse
- dfp_addr  out  32  line address; [4:0] is always 0
- dfp_read  out  1  line fill request
- dfp_write  out  1  line write-back request
- dfp_wdata  out  256  write-back line
- dfp_rdata  in  256  fill line
- dfp_resp  in  1  one-cycle completion of the current DFP request
- flush_req  in  1  one-cycle pulse: write back every dirty line
- flush_inv  in  1  sampled with flush_req; 1 also clears every valid bit
- flush_done  out  1  one-cycle pulse when the walk completes
- busy  out  1  1 in any state except IDLE
- hit_count  out  32  completed hits, wraps modulo 2^32
- miss_count  out  32  COMPARE misses, wraps modulo 2^32

## Operation

- Per-way per-set state: valid, dirty, tag[TAG_W-1:0], and a 256-bit line. Per-set state: PLRU tree of NUM_WAYS-1 bits.
- Address split: tag = addr[31:5+IDX_W], index = addr[4+IDX_W:5], word = addr[4:2].
- The UFP request stays stable from the cycle it is raised until ufp_resp.
- States: IDLE, COMPARE, WRITE_BACK, ALLOCATE, STALL, FLUSH_SCAN, FLUSH_WB.
- IDLE:
  - flush_req=1 -> FLUSH_SCAN. Flush beats a simultaneous UFP request; the request waits.
  - Otherwise, rmask|wmask nonzero -> COMPARE.
- COMPARE, hit (valid and tag match; ways are unique by construction):
  - Read: ufp_rdata = selected word, with bytes whose rmask bit is 0 driven to 0.
  - Write: merge the wmask bytes into the word and set dirty.
  - Assert ufp_resp, update PLRU toward the hit way, increment hit_count, go to IDLE.
- COMPARE, miss:
  - Increment miss_count. This happens once per COMPARE miss, so the post-fill COMPARE counts a hit.
  - Victim = lowest-index invalid way; if all ways are valid, the PLRU victim.
  - Victim valid and dirty -> WRITE_BACK; otherwise -> ALLOCATE.
- WRITE_BACK:
  - dfp_write=1, dfp_addr = {victim tag, index, 5'b0}, dfp_wdata = victim line.
  - On dfp_resp: clear dirty, go to ALLOCATE.
- ALLOCATE:
  - dfp_read=1, dfp_addr = {ufp_addr[31:5], 5'b0}.
  - On dfp_resp: write dfp_rdata into the victim, set valid, set the new tag, clear dirty, go to STALL.
- STALL -> COMPARE. The retry then hits.
- PLRU:
  - Bit=0 means the victim lies in the left (lower-index) subtree.
  - On access, set each bit on the path to point away from the accessed way.
- Flush:
  - A way/set pointer starts at (set 0, way 0) and walks ways inner, sets outer.
  - FLUSH_SCAN: if the entry is valid and dirty -> FLUSH_WB. Otherwise apply the invalidate (if flush_inv) and advance.
  - FLUSH_WB: dfp_write on that line. On dfp_resp: clear dirty, clear valid if flush_inv, advance, return to FLUSH_SCAN.
  - After the last entry: flush_done=1 for one cycle, go to IDLE.
  - PLRU state is cleared to 0 when flush_inv=1 and left unchanged otherwise.
- flush_req outside IDLE is ignored.
- Reset (asynchronous, any state, including mid-DFP transaction):
  - State -> IDLE.
  - All valid, dirty, and PLRU bits -> 0; both counters -> 0.
  - ufp_resp, dfp_read, dfp_write, flush_done, busy -> 0.
  - Line data and tags are not reset.
  - A DFP transaction in progress is abandoned; memory must tolerate a dropped request.

## Timing

- Read/write hit: request raised in cycle N (IDLE), ufp_resp in N+1.
- Clean miss: COMPARE at N+1, ALLOCATE from N+2. If dfp_resp arrives at cycle M: STALL at M+1, COMPARE and ufp_resp at M+2.
- Dirty miss: WRITE_BACK from N+2 until its dfp_resp, then the same ALLOCATE sequence.
- dfp_read, dfp_write, dfp_addr, and dfp_wdata hold steady until the dfp_resp cycle and deassert the cycle after. dfp_read and dfp_write are never both 1.
- Flush of C clean entries with no dirty lines takes C cycles in FLUSH_SCAN; flush_done follows one cycle later.
- busy rises the cycle after a request or flush is accepted.

## Test plan

- Reset, then read 0x0000_1004 with rmask=4'hF, memory line = 0x...AABBCCDD in word 1 -> one dfp_read at 0x0000_1000, ufp_rdata=0xAABBCCDD at dfp_resp+2, miss_count=1, hit_count=1.
- Write 0x12345678 with wmask=4'b0011 to a resident word 0xAABBCCDD, then read -> 0xAABB5678, no DFP traffic, hit latency of one cycle.
- NUM_WAYS=4: fill five tags into one set with the fourth line dirty, access order A,B,C,D,E -> victim is A (clean, no dfp_write); make A dirty on a re-fill and evict it -> dfp_write at A's address before dfp_read.
- Three dirty lines in sets 0, 5, and 15, then flush_req with flush_inv=1 -> exactly three dfp_writes in ascending set order, flush_done pulse, and every later read misses.
- flush_req and a read raised in the same IDLE cycle -> the flush completes first, then the read is serviced.
- rst_n pulled low while dfp_read is high -> all outputs 0 immediately; after release, a read of the same address misses.
